muldiv_hilo_unit: RTL and testbench

- Parametrised iterative multiply/divide unit that owns the HI/LO register pair; successor to the ALU's inline mult/div path.
- Supports signed/unsigned multiply, divide, multiply-accumulate and multiply-subtract, with a start/busy/done handshake and an annul input.
- Sits beside the EX-stage ALU. The pipeline stalls on busy_o and reads hi_o/lo_o for MFHI/MFLO.

---
 rtl/muldiv_hilo_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_hilo_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_unit.sv
// Iterative signed/unsigned multiply, divide, multiply-accumulate and
// multiply-subtract unit that owns the HI/LO register pair.
module muldiv_hilo_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             annul_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, mag_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] p_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_q, neg_r_q, dz_q, done_q, div_zero_q;

  logic               is_div, is_sgn, a_neg, b_neg, b_zero, div_ge;
  logic [WIDTH-1:0]   a_mag, b_mag, addend, quot, rem;
  logic [WIDTH:0]     mul_sum, div_tmp, div_sub;
  logic [2*WIDTH-1:0] mul_next, div_next, prod, mul_res;

  always_comb begin
    is_div  = (op_q[2:1] == 2'b01);
    is_sgn  = ~op_q[0];
    a_neg   = is_sgn & a_q[WIDTH-1];
    b_neg   = is_sgn & b_q[WIDTH-1];
    a_mag   = a_neg ? -a_q : a_q;
    b_mag   = b_neg ? -b_q : b_q;
    b_zero  = (b_q == '0);

    // p_q holds {partial product, multiplier} for multiply and
    // {partial remainder, dividend/quotient} for divide.
    addend   = p_q[0] ? mag_q : '0;
    mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    mul_next = {mul_sum, p_q[WIDTH-1:1]};

    div_tmp  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    div_sub  = div_tmp - {1'b0, mag_q};
    div_ge   = ~div_sub[WIDTH];
    div_next = {(div_ge ? div_sub[WIDTH-1:0] : div_tmp[WIDTH-1:0]),
                p_q[WIDTH-2:0], div_ge};

    prod = neg_q ? -p_q : p_q;
    quot = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    rem  = neg_r_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    unique case (op_q[2:1])
      2'b10:   mul_res = {hi_q, lo_q} + prod;
      2'b11:   mul_res = {hi_q, lo_q} - prod;
      default: mul_res = prod;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_i) state_d = S_PREP;
      S_PREP: begin
        if (annul_i)              state_d = S_IDLE;
        else if (is_div && b_zero) state_d = S_FIX;
        else                      state_d = S_RUN;
      end
      S_RUN: begin
        if (annul_i)            state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_FIX;
      end
      S_FIX: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      mag_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      p_q        <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      neg_r_q    <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (hi_we_i) hi_q <= wdata_i;
          if (lo_we_i) lo_q <= wdata_i;
          if (start_i) begin
            op_q <= op_i;
            a_q  <= a_i;
            b_q  <= b_i;
          end
        end
        S_PREP: begin
          neg_q   <= a_neg ^ b_neg;
          neg_r_q <= a_neg;
          dz_q    <= is_div & b_zero;
          cnt_q   <= CW'(WIDTH - 1);
          mag_q   <= is_div ? b_mag : a_mag;
          p_q     <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
        end
        S_RUN: begin
          p_q   <= is_div ? div_next : mul_next;
          cnt_q <= cnt_q - 1'b1;
        end
        S_FIX: begin
          if (!annul_i) begin
            done_q     <= 1'b1;
            div_zero_q <= dz_q;
            if (dz_q) begin
              hi_q <= a_q;
              lo_q <= '1;
            end else if (is_div) begin
              hi_q <= rem;
              lo_q <= quot;
            end else begin
              {hi_q, lo_q} <= mul_res;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;
  assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Randomised and directed bench for muldiv_hilo_unit (WIDTH=32 and WIDTH=8),
// checked against an arithmetic reference model.
module tb_muldiv_hilo_unit;

  typedef struct packed {
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, annul = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic [31:0] hi, lo;
  logic        busy, done, dz;

  logic        start8 = 1'b0, annul8 = 1'b0, hi_we8 = 1'b0, lo_we8 = 1'b0;
  logic [2:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0, wdata8 = '0;
  logic [7:0]  hi8, lo8;
  logic        busy8, done8, dz8;

  muldiv_hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .annul_i(annul), .hi_we_i(hi_we), .lo_we_i(lo_we), .wdata_i(wdata),
    .hi_o(hi), .lo_o(lo), .busy_o(busy), .done_o(done), .div_zero_o(dz)
  );

  muldiv_hilo_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .op_i(op8), .a_i(a8), .b_i(b8),
    .annul_i(annul8), .hi_we_i(hi_we8), .lo_we_i(lo_we8), .wdata_i(wdata8),
    .hi_o(hi8), .lo_o(lo8), .busy_o(busy8), .done_o(done8), .div_zero_o(dz8)
  );

  // Reference arithmetic on w-bit operands using wide integer math.
  function automatic res_t model_op(input int w, input logic [2:0] o,
                                    input logic [31:0] av, input logic [31:0] bv,
                                    input logic [31:0] hv, input logic [31:0] lv);
    logic [127:0] mask, mask2, acc, u;
    logic signed [127:0] sa, sb, q, rr, r;
    res_t res;
    mask  = (128'd1 << w) - 128'd1;
    mask2 = (128'd1 << (2 * w)) - 128'd1;
    sa = {96'd0, av} & mask;
    sb = {96'd0, bv} & mask;
    if (!o[0]) begin
      if (av[w-1]) sa = sa | ~mask;
      if (bv[w-1]) sb = sb | ~mask;
    end
    res = '0;
    if (o[2:1] == 2'b01) begin
      if (({96'd0, bv} & mask) == 128'd0) begin
        res.dz = 1'b1;
        res.lo = 32'(mask);
        res.hi = av;
      end else begin
        q  = sa / sb;
        rr = sa % sb;
        res.lo = 32'(q & mask);
        res.hi = 32'(rr & mask);
      end
    end else begin
      r   = sa * sb;
      acc = ((({96'd0, hv}) & mask) << w) | (({96'd0, lv}) & mask);
      if (o[2:1] == 2'b10)      u = acc + r;
      else if (o[2:1] == 2'b11) u = acc - r;
      else                      u = r;
      u = u & mask2;
      res.lo = 32'(u & mask);
      res.hi = 32'((u >> w) & mask);
    end
    return res;
  endfunction

  // Transaction-level model of the 32-bit unit: pending op plus edge countdown.
  logic [31:0] m_hi = '0, m_lo = '0, p_a = '0, p_b = '0;
  logic [2:0]  p_op = '0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  int          m_cnt = 0;
  res_t        m_res;

  always_comb m_res = model_op(32, p_op, p_a, p_b, m_hi, m_lo);

  always @(posedge clk) begin
    if (!rst) begin
      m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0; m_cnt <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (annul) m_busy <= 1'b0;
        else if (m_cnt == 1) begin
          m_hi <= m_res.hi; m_lo <= m_res.lo; m_dz <= m_res.dz;
          m_done <= 1'b1; m_busy <= 1'b0; m_cnt <= 0;
        end else m_cnt <= m_cnt - 1;
      end else begin
        if (hi_we) m_hi <= wdata;
        if (lo_we) m_lo <= wdata;
        if (start) begin
          p_op <= op; p_a <= a; p_b <= b; m_busy <= 1'b1;
          m_cnt <= (op[2:1] == 2'b01 && b == '0) ? 2 : 34;
        end
      end
    end
  end

  int   c_chk = 0, c_pass = 0, d_chk = 0, d_pass = 0;
  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      c_chk <= c_chk + 1;
      if ({hi, lo, busy, done, dz} === {m_hi, m_lo, m_busy, m_done, m_dz})
        c_pass <= c_pass + 1;
      else
        $display("FAIL cycle t=%0t: hi=%h lo=%h busy=%b done=%b dz=%b expected hi=%h lo=%h busy=%b done=%b dz=%b",
                 $time, hi, lo, busy, done, dz, m_hi, m_lo, m_busy, m_done, m_dz);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    d_chk++;
    if (act === exp) d_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic hw, input logic lw, input logic [31:0] wd);
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    op = o; a = x; b = y; start = 1'b1; hi_we = hw; lo_we = lw; wdata = wd;
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  task automatic wait32(output int edges);
    edges = 0;
    while (!done && edges < 200) begin tick(); edges++; end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  logic [7:0] e8h = '0, e8l = '0;

  task automatic run8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int n = 0, edges = 0;
    res_t r;
    while (busy8 && n < 100) begin tick(); n++; end
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    while (!done8 && edges < 100) begin tick(); edges++; end
    r = model_op(8, o, {24'd0, x}, {24'd0, y}, {24'd0, e8h}, {24'd0, e8l});
    e8h = r.hi[7:0]; e8l = r.lo[7:0];
    chk("w8_latency", 64'(edges), (r.dz ? 64'd2 : 64'd10));
    chk("w8_hilo", {48'd0, hi8, lo8}, {48'd0, e8h, e8l});
    chk("w8_divzero", {63'd0, dz8}, {63'd0, r.dz});
    tick();
  endtask

  initial begin
    int e;
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_state", {hi, lo}, 64'd0);
    chk("reset_flags", {61'd0, busy, done, dz}, 64'd0);
    rst = 1'b1;
    tick();

    start32(3'b000, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, '0); wait32(e);
    chk("mult_latency", 64'(e), 64'd34);
    chk("mult_neg2x3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    start32(3'b001, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, '0); wait32(e);
    chk("multu", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
    start32(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0); wait32(e);
    chk("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    start32(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0); wait32(e);
    chk("divu_big", {hi, lo}, 64'h8000_0000_0000_0000);
    start32(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0); wait32(e);
    chk("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);
    chk("div_overflow_flag", {63'd0, dz}, 64'd0);

    start32(3'b011, 32'd5, 32'd0, 1'b0, 1'b0, '0); wait32(e);
    chk("divzero_latency", 64'(e), 64'd2);
    chk("divzero_hilo", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
    chk("divzero_flag", {63'd0, dz}, 64'd1);
    start32(3'b001, 32'd1, 32'd1, 1'b0, 1'b0, '0); wait32(e);
    chk("divzero_cleared", {63'd0, dz}, 64'd0);

    start32(3'b001, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0); wait32(e);
    start32(3'b100, 32'hFFFF_FFFD, 32'd4, 1'b0, 1'b1, 32'd10); wait32(e);
    chk("madd_after_mtlo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    start32(3'b111, 32'd1, 32'd1, 1'b0, 1'b0, '0); wait32(e);
    chk("msubu_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);

    start32(3'b000, 32'd7, 32'd9, 1'b0, 1'b0, '0);
    repeat (11) tick();
    annul = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();
    annul = 1'b0; hi_we = 1'b0;
    chk("annul_busy_done", {62'd0, busy, done}, 64'd0);
    chk("annul_hilo_kept", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    start32(3'b000, 32'd7, 32'd9, 1'b0, 1'b0, '0); wait32(e);
    chk("restart_latency", 64'(e), 64'd34);
    chk("restart_hilo", {hi, lo}, 64'd63);

    start32(3'b000, 32'd12345, 32'd678, 1'b0, 1'b0, '0);
    repeat (5) tick();
    rst = 1'b0;
    tick();
    chk("midrun_reset", {hi, lo, 29'd0, busy, done, dz}, 96'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      op    = 3'($urandom);
      a     = pick();
      b     = pick();
      annul = ($urandom_range(0, 79) == 0);
      hi_we = ($urandom_range(0, 7) == 0);
      lo_we = ($urandom_range(0, 7) == 0);
      wdata = $urandom;
      tick();
    end
    start = 1'b0; annul = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (40) tick();

    run8(3'b000, 8'hFE, 8'd3);
    chk("w8_mult_lit", {48'd0, hi8, lo8}, 64'h0000_0000_0000_FFFA);
    for (int i = 0; i < 20; i++)
      run8(3'($urandom), 8'($urandom),
           ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom));

    $display("%0d/%0d checks passed", c_pass + d_pass, c_chk + d_chk);
    $finish;
  end

endmodule
